f1_start_ctrl: RTL

Race-start sequencer for the F1 light gantry. It runs the start sequence on request: eight lights build one per tick, then a pseudo-random hold, then lights out. After lights out it times the driver's reaction in clock cycles and flags a false start. It sits between the board's trigger/react buttons and the 8-bit light bar, with its own tick prescaler.

---
 rtl/f1_start_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/f1_start_ctrl.sv
// ---------------------------------------------------------------------------
// f1_start_ctrl
//
// Race-start sequencer for the F1 light gantry. On a trigger it builds the
// eight lights one per tick, holds them all on for a pseudo-random number of
// ticks (1..127), then switches them off and times the driver's reaction in
// clk cycles. Pressing react before lights out is a false start.
//
// Ports
//   clk          system clock, single clock domain
//   rst          synchronous active-high reset
//   N            tick period minus one (one tick every N+1 cycles)
//   trigger      start request, only honoured in IDLE
//   react        driver button, level sensitive
//   data_out     light bar, bit i drives light i
//   busy         high whenever the sequencer is not IDLE
//   time_valid   one-cycle pulse when react_time is updated
//   react_time   last measured reaction time in clk cycles (saturating)
//   false_start  react seen before lights out; held until the next trigger
//
// All outputs are registered: the comb process computes next values for
// every register, the sequential process only stores them.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lights off, waiting for trigger
// BUILD | one more light on per tick until all eight are lit
// HOLD  | all lights on, counting down the random hold delay in ticks
// GO    | lights out, reaction counter running until react
// ---------------------------------------------------------------------------
module f1_start_ctrl #(
   parameter int N_WIDTH    = 16,
   parameter int TIME_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_WIDTH-1:0]    N,
   input  logic                  trigger,
   input  logic                  react,
   output logic [7:0]            data_out,
   output logic                  busy,
   output logic                  time_valid,
   output logic [TIME_WIDTH-1:0] react_time,
   output logic                  false_start
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      HOLD  = 2'd2,
      GO    = 2'd3
   } state_t;

   localparam logic [N_WIDTH-1:0]    PRESC_ONE = N_WIDTH'(1);
   localparam logic [TIME_WIDTH-1:0] RCNT_ONE  = TIME_WIDTH'(1);
   localparam logic [6:0]            LFSR_SEED = 7'h01;

   state_t                state, state_nxt;
   logic [N_WIDTH-1:0]    presc, presc_nxt;
   logic [6:0]            delay, delay_nxt;
   logic [6:0]            lfsr;
   logic [TIME_WIDTH-1:0] rcnt, rcnt_nxt;
   logic [7:0]            data_nxt;
   logic                  busy_nxt;
   logic                  tv_nxt;
   logic                  fs_nxt;
   logic [TIME_WIDTH-1:0] rt_nxt;
   logic                  tick;
   logic [N_WIDTH-1:0]    presc_run;

   // Terminal count of the tick prescaler. N is picked up only at reload,
   // so a new period starts cleanly on the next tick.
   assign tick      = (presc == '0);
   assign presc_run = tick ? N : (presc - PRESC_ONE);

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      delay_nxt = delay;
      rcnt_nxt  = rcnt;
      data_nxt  = data_out;
      tv_nxt    = 1'b0;
      fs_nxt    = false_start;
      rt_nxt    = react_time;

      unique case (state)
         IDLE: begin
            data_nxt = '0;
            // trigger takes priority over react here; react is ignored
            if (trigger) begin
               state_nxt = BUILD;
               presc_nxt = N;
               fs_nxt    = 1'b0;
            end
         end

         BUILD: begin
            if (react) begin
               fs_nxt    = 1'b1;
               data_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               presc_nxt = presc_run;
               if (tick) begin
                  data_nxt = {data_out[6:0], 1'b1};
                  // this tick lights the eighth lamp
                  if (data_out == 8'h7F) begin
                     state_nxt = HOLD;
                     delay_nxt = lfsr;
                  end
               end
            end
         end

         HOLD: begin
            // react on the final hold tick is still a false start
            if (react) begin
               fs_nxt    = 1'b1;
               data_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               presc_nxt = presc_run;
               if (tick) begin
                  if (delay == 7'd1) begin
                     state_nxt = GO;
                     data_nxt  = '0;
                     rcnt_nxt  = '0;
                  end else begin
                     delay_nxt = delay - 7'd1;
                  end
               end
            end
         end

         GO: begin
            data_nxt = '0;
            if (react) begin
               rt_nxt    = rcnt;
               tv_nxt    = 1'b1;
               state_nxt = IDLE;
            end else if (rcnt != '1) begin
               rcnt_nxt = rcnt + RCNT_ONE;
            end
         end

         default: begin
            state_nxt = IDLE;
            data_nxt  = '0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         delay       <= '0;
         lfsr        <= LFSR_SEED;
         rcnt        <= '0;
         data_out    <= '0;
         busy        <= 1'b0;
         time_valid  <= 1'b0;
         react_time  <= '0;
         false_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         presc       <= presc_nxt;
         delay       <= delay_nxt;
         // x^7 + x^6 + 1, free running so the hold delay depends on when
         // the trigger arrives; a maximal-length sequence never hits zero
         lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
         rcnt        <= rcnt_nxt;
         data_out    <= data_nxt;
         busy        <= busy_nxt;
         time_valid  <= tv_nxt;
         react_time  <= rt_nxt;
         false_start <= fs_nxt;
      end
   end

endmodule
